// File: rtl/ram_arbiter2.sv
// Two-requester round-robin arbiter in front of the single shared RAM port.
// Requester 0 is instruction fetch, requester 1 is data load/store.
module ram_arbiter2 #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              req0_ren,
    input  logic              req0_wen,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_store,
    output logic [DATA_W-1:0] req0_load,
    output logic              req0_wait,
    output logic              req0_err,
    input  logic              req1_ren,
    input  logic              req1_wen,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_store,
    output logic [DATA_W-1:0] req1_load,
    output logic              req1_wait,
    output logic              req1_err,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic [1:0]        ram_state
);

    typedef enum logic {IDLE, SERVE} state_t;
    typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ram_st_t;

    state_t     state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_q,  last_d;
    logic [7:0] cnt_q,   cnt_d;

    logic              act0, act1;
    logic              g_act, g_ren, g_wen;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_store;
    logic              done, fail;
    ram_st_t           rst_in;

    assign act0    = req0_ren | req0_wen;
    assign act1    = req1_ren | req1_wen;
    assign g_ren   = grant_q ? req1_ren   : req0_ren;
    assign g_wen   = grant_q ? req1_wen   : req0_wen;
    assign g_addr  = grant_q ? req1_addr  : req0_addr;
    assign g_store = grant_q ? req1_store : req0_store;
    assign g_act   = g_ren | g_wen;
    assign rst_in  = ram_st_t'(ram_state);

    // ACCESS wins over a simultaneous ERROR/timeout
    assign done = (rst_in == RAM_ACCESS);
    assign fail = ~done & ((rst_in == RAM_ERROR) || (cnt_q == 8'(TIMEOUT - 1)));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        req0_load = '0;
        req1_load = '0;
        req0_err  = 1'b0;
        req1_err  = 1'b0;
        req0_wait = act0;
        req1_wait = act1;
        case (state_q)
            IDLE: begin
                if (act0 | act1) begin
                    grant_d = (act0 & act1) ? ~last_q : act1;
                    cnt_d   = '0;
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (!g_act) begin
                    // requester withdrew: abort quietly, round-robin pointer untouched
                    state_d = IDLE;
                end else begin
                    ram_ren   = g_ren & ~g_wen;
                    ram_wen   = g_wen;
                    ram_addr  = g_addr;
                    ram_store = g_store;
                    if (cnt_q != 8'(TIMEOUT))
                        cnt_d = cnt_q + 8'd1;
                    if (done | fail) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                        if (grant_q) begin
                            req1_wait = 1'b0;
                            req1_err  = fail;
                            req1_load = done ? ram_load : '0;
                        end else begin
                            req0_wait = 1'b0;
                            req0_err  = fail;
                            req0_load = done ? ram_load : '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
